approx_mult_seq: RTL and testbench

Sequential, parametrised approximate multiplier: multiplies two `WIDTH`-bit unsigned operands by walking the 4x4 sub-product tiles one per cycle. Low-weight tiles use a truncated approximate 4x4 product; all other tiles are exact. A per-transaction `in_exact` bit forces every tile exact. The block sits between a valid/ready operand source and a valid/ready result sink. It is the multi-cycle, width-generic successor of the fixed 8x8 tile-composed multipliers.

---
 rtl/approx_mult_pkg.sv | 18 +
 rtl/approx_mult_seq_tile.sv | 19 +
 rtl/approx_mult_seq.sv | 149 ++++++++++++++
 tb/tb_approx_mult_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the sequential approximate multiplier.
// Tile geometry, FSM state encoding and the tile-approximation predicate.
package approx_mult_pkg;

  localparam int TILE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Tiles on the low-weight anti-diagonals (i+j below the threshold) are approximate.
  function automatic logic is_approx(input int i, input int j, input int approx_diag);
    return (i + j) < approx_diag;
  endfunction

endpackage

// File: rtl/approx_mult_seq_tile.sv
// Combinational 4x4 tile multiplier: exact a*b, or a truncated product
// that drops both operand LSBs and restores the weight with two zero bits.
module approx_tile_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       approx,
  output logic [7:0] p
);

  logic [7:0] p_exact;
  logic [5:0] p_trunc;

  always_comb begin
    p_exact = {4'b0000, a} * {4'b0000, b};
    p_trunc = {3'b000, a[3:1]} * {3'b000, b[3:1]};
    p       = approx ? {p_trunc, 2'b00} : p_exact;
  end

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential approximate multiplier: accumulates one 4x4 tile per cycle.
// Define APPROX_MULT_OR_ACC_EN to merge approximate tiles by OR instead of add.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid, once raised by the block, holds with stable data until that edge.
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_DIAG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_exact,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r,
  output logic               busy
);

  localparam int N     = WIDTH / TILE_W;
  localparam int NT    = N * N;
  localparam int CNT_W = $clog2(NT);
  localparam int AW    = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               exact_q, exact_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [AW-1:0]      out_r_q, out_r_d;
  logic               out_valid_q, out_valid_d;

  int                 ti, tj;
  logic [3:0]         tile_a, tile_b;
  logic               tile_approx;
  logic [7:0]         tile_p;
  logic [AW-1:0]      tile_sh;
  logic [AW-1:0]      acc_next;
  logic               last_tile;

  // Tile selection: i walks the multiplicand nibbles fastest.
  always_comb begin
    ti          = int'(cnt_q) % N;
    tj          = int'(cnt_q) / N;
    tile_a      = 4'(a_q >> (TILE_W * ti));
    tile_b      = 4'(b_q >> (TILE_W * tj));
    tile_approx = !exact_q && is_approx(ti, tj, APPROX_DIAG);
    last_tile   = (cnt_q == CNT_W'(NT - 1));
  end

  approx_tile_4x4 u_tile (
    .a      (tile_a),
    .b      (tile_b),
    .approx (tile_approx),
    .p      (tile_p)
  );

  always_comb begin
    tile_sh = {{(AW-8){1'b0}}, tile_p} << (TILE_W * (ti + tj));
`ifdef APPROX_MULT_OR_ACC_EN
    acc_next = tile_approx ? (acc_q | tile_sh) : (acc_q + tile_sh);
`else
    acc_next = acc_q + tile_sh;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_tile) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    exact_d     = exact_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_r_d     = out_r_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          exact_d = in_exact;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_tile) begin
          cnt_d       = '0;
          out_r_d     = acc_next;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      exact_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      exact_q     <= exact_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Self-checking bench for approx_mult_seq at WIDTH=8 (diag 1) and WIDTH=16 (diag 0).
module tb_approx_mult_seq;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid8, in_ready8, ex8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        in_valid16, in_ready16, ex16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  approx_mult_seq #(.WIDTH(8), .APPROX_DIAG(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(a8), .in_b(b8), .in_exact(ex8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_r(r8), .busy(busy8)
  );

  approx_mult_seq #(.WIDTH(16), .APPROX_DIAG(0)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(a16), .in_b(b16), .in_exact(ex16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_r(r16), .busy(busy16)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q8[$];
  logic [31:0] exp_q16[$];
  int          acc_cyc8, acc_cyc16;
  logic        ov8_prev, ov16_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact product corrected for the single approximate low tile (0,0).
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ex);
    logic [15:0] p;
    logic [7:0]  t_exact;
    logic [5:0]  t_trunc;
    p = {8'h00, a} * {8'h00, b};
    t_exact = {4'h0, a[3:0]} * {4'h0, b[3:0]};
    t_trunc = {3'b000, a[3:1]} * {3'b000, b[3:1]};
    if (!ex) p = p - {8'h00, t_exact} + {8'h00, t_trunc, 2'b00};
    return p;
  endfunction

  // Scoreboard monitors: sample on the falling edge, pop on a pending handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov8_prev <= 1'b0;
    end else begin
      if (out_valid8 && !ov8_prev) check("lat8", 64'(cyc - acc_cyc8), 64'd4);
      if (out_valid8 && out_ready8) begin
        if (exp_q8.size() == 0) check("spurious8", 64'(exp_q8.size()), 64'd1);
        else check("r8", 64'(r8), 64'(exp_q8.pop_front()));
      end
      ov8_prev <= out_valid8;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      ov16_prev <= 1'b0;
    end else begin
      if (out_valid16 && !ov16_prev) check("lat16", 64'(cyc - acc_cyc16), 64'd16);
      if (out_valid16 && out_ready16) begin
        if (exp_q16.size() == 0) check("spurious16", 64'(exp_q16.size()), 64'd1);
        else check("r16", 64'(r16), 64'(exp_q16.pop_front()));
      end
      ov16_prev <= out_valid16;
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ex, output int waited);
    int t = 0;
    @(posedge clk); #1;
    a8 = a; b8 = b; ex8 = ex; in_valid8 = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready8 && t < 100);
    waited = t;
    if (!in_ready8) begin
      check("accept8", 64'(in_ready8), 64'd1);
    end else begin
      exp_q8.push_back(model8(a, b, ex));
      acc_cyc8 = cyc + 1;
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    ex8 = 1'($urandom);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ex);
    int t = 0;
    @(posedge clk); #1;
    a16 = a; b16 = b; ex16 = ex; in_valid16 = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready16 && t < 100);
    if (!in_ready16) begin
      check("accept16", 64'(in_ready16), 64'd1);
    end else begin
      exp_q16.push_back({16'h0000, a} * {16'h0000, b});
      acc_cyc16 = cyc + 1;
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
  endtask

  task automatic drain8();
    int t = 0;
    while (exp_q8.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain8", 64'(exp_q8.size()), 64'd0);
  endtask

  task automatic drain16();
    int t = 0;
    while (exp_q16.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain16", 64'(exp_q16.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          w;
    int          t;
    logic [15:0] cap;
    logic [7:0]  ra, rb;

    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; ex8 = 1'b0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; ex16 = 1'b0; out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready8", 64'(in_ready8), 64'd1);
    check("rst_out_valid8", 64'(out_valid8), 64'd0);
    check("rst_out_r8", 64'(r8), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_out_valid16", 64'(out_valid16), 64'd0);

    // Directed WIDTH=8 vectors.
    send8(8'hFF, 8'hFF, 1'b1, w);
    @(negedge clk);
    check("run_busy8", 64'(busy8), 64'd1);
    check("run_in_ready8", 64'(in_ready8), 64'd0);
    drain8();
    check("ff_exact", 64'(r8), 64'hFE01);
    send8(8'hFF, 8'hFF, 1'b0, w); drain8();
    check("ff_approx", 64'(r8), 64'hFDE4);
    send8(8'h03, 8'h05, 1'b0, w); drain8();
    check("3x5_approx", 64'(r8), 64'h0008);
    send8(8'h03, 8'h05, 1'b1, w); drain8();
    check("3x5_exact", 64'(r8), 64'h000F);
    send8(8'h00, 8'($urandom), 1'b0, w); drain8();
    check("zero_a", 64'(r8), 64'h0000);
    send8(8'hA7, 8'h3C, 1'b0, w); drain8();
    repeat (3) @(negedge clk);
    check("idle_hold8", 64'(r8), 64'(model8(8'hA7, 8'h3C, 1'b0)));

    // Random WIDTH=8 traffic.
    for (int k = 0; k < 16; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send8(ra, rb, 1'($urandom_range(0, 1)), w);
      drain8();
    end

    // Backpressure in DONE.
    @(posedge clk); #1 out_ready8 = 1'b0;
    send8(8'hA5, 8'h3C, 1'b0, w);
    t = 0;
    while (!out_valid8 && t < 20) begin
      @(negedge clk);
      t++;
    end
    cap = r8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid8), 64'd1);
      check("bp_stable", 64'(r8), 64'(cap));
      check("bp_in_ready", 64'(in_ready8), 64'd0);
    end
    check("bp_value", 64'(cap), 64'(model8(8'hA5, 8'h3C, 1'b0)));
    @(posedge clk); #1 out_ready8 = 1'b1;
    send8(8'h12, 8'h34, 1'b1, w);
    check("bp_next_accept_wait", 64'(w), 64'd1);
    drain8();

    // Reset during RUN: aborted operands must not emit a result.
    send8(8'hFF, 8'hFF, 1'b0, w);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", 64'(out_valid8), 64'd0);
    check("abort_out_r", 64'(r8), 64'd0);
    check("abort_busy", 64'(busy8), 64'd0);
    exp_q8.delete();
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready8), 64'd1);
    repeat (8) @(negedge clk);
    check("abort_no_result", 64'(out_valid8), 64'd0);
    send8(8'h03, 8'h05, 1'b1, w); drain8();

    // WIDTH=16, all tiles exact.
    send16(16'hFFFF, 16'hFFFF, 1'b0); drain16();
    check("ffff_exact16", 64'(r16), 64'hFFFE0001);
    for (int k = 0; k < 6; k++) begin
      send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      drain16();
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
